// File: rtl/shift_sequencer.sv
// Multicycle shift unit for the execute stage: SLL/SRL/SRA/ROL, one bit position per clock,
// with a start/ready handshake shared with the multdiv unit.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_abort,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             busy_q;
  logic             rdy_q;
  logic [WIDTH-1:0] step;

  always_comb begin
    step = acc;
    case (op_q)
      2'b00:   step = {acc[WIDTH-2:0], 1'b0};
      2'b01:   step = {1'b0, acc[WIDTH-1:1]};
      2'b10:   step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: step = {acc[WIDTH-2:0], acc[WIDTH-1]};
    endcase
  end

  // busy/RDY are registered alongside the state so they decode to exactly SHIFT and DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= 2'b00;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ctrl_start) begin
            acc    <= data_in;
            op_q   <= op;
            cnt    <= shamt;
            state  <= (shamt != '0) ? SHIFT : DONE;
            busy_q <= (shamt != '0);
            rdy_q  <= (shamt == '0);
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rdy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          // A flush leaves the partially shifted value visible but never signals ready.
          if (ctrl_abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rdy_q  <= 1'b0;
          end else begin
            acc <= step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              rdy_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              rdy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          rdy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = acc;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table-driven ops plus hand-written
// sequences for reset, back-to-back, ignored start and abort.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_abort;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_abort     (ctrl_abort),
    .op             (op),
    .shamt          (shamt),
    .data_in        (data_in),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepts one request, then follows it edge by edge until RDY (bounded).
  // pulse_at >= 0 raises a junk ctrl_start for one cycle after that many edges.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                        input int pulse_at,
                        output logic [31:0] res, output int lat, output int busy_cycles);
    @(negedge clock);
    ctrl_start = 1'b1; op = o; shamt = s; data_in = d;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!data_resultRDY && lat < 40) begin
      if (busy) busy_cycles++;
      if (lat == pulse_at) begin
        ctrl_start = 1'b1; op = 2'b01; shamt = 5'd0; data_in = 32'hFFFF_FFFF;
      end else begin
        ctrl_start = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    ctrl_start = 1'b0;
    res = data_result;
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int bcyc;
    int seen;

    vecs[0] = '{2'b00, 5'd4,  32'h8000_00F1, 32'h0000_0F10, 4};
    vecs[1] = '{2'b01, 5'd4,  32'h8000_00F1, 32'h0800_000F, 4};
    vecs[2] = '{2'b10, 5'd4,  32'h8000_00F1, 32'hF800_000F, 4};
    vecs[3] = '{2'b11, 5'd4,  32'h8000_00F1, 32'h0000_0F18, 4};
    vecs[4] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[5] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31};
    vecs[6] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 31};
    vecs[7] = '{2'b11, 5'd31, 32'h0000_0001, 32'h8000_0000, 31};
    vecs[8] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 31};

    ctrl_start = 1'b0; ctrl_abort = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("reset_result", data_result, 32'h0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].shamt, vecs[i].din, -1, res, lat, bcyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].exp_lat);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_rdy_drop", i), {31'b0, data_resultRDY}, 32'h0);
      check($sformatf("vec%0d_hold", i), data_result, vecs[i].exp_res);
    end

    // Reset in the middle of a long shift.
    @(negedge clock);
    ctrl_start = 1'b1; op = 2'b00; shamt = 5'd20; data_in = 32'h0000_0001;
    @(posedge clock);
    #1 ctrl_start = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_result", data_result, 32'h0);
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    repeat (5) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    check("postreset_busy", {31'b0, busy}, 32'h0);
    check("postreset_result", data_result, 32'h0);
    run_op(2'b00, 5'd4, 32'h0000_0001, -1, res, lat, bcyc);
    check("postreset_sll4", res, 32'h0000_0010);
    check("postreset_latency", lat, 4);

    // Back-to-back: new request raised during the DONE cycle.
    run_op(2'b00, 5'd2, 32'h0000_0001, -1, res, lat, bcyc);
    check("b2b_first", res, 32'h0000_0004);
    ctrl_start = 1'b1; op = 2'b01; shamt = 5'd1; data_in = 32'h0000_0002;
    @(posedge clock);
    #1 ctrl_start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'h1);
    check("b2b_rdy_low", {31'b0, data_resultRDY}, 32'h0);
    @(posedge clock);
    #1;
    check("b2b_rdy", {31'b0, data_resultRDY}, 32'h1);
    check("b2b_result", data_result, 32'h0000_0001);

    // Start pulsed mid-shift is dropped.
    run_op(2'b00, 5'd6, 32'h0000_0001, 2, res, lat, bcyc);
    check("ignored_start_result", res, 32'h0000_0040);
    check("ignored_start_latency", lat, 6);
    @(posedge clock);
    #1;
    check("ignored_start_idle", {30'b0, busy, data_resultRDY}, 32'h0);

    // Abort after three ROL steps.
    @(negedge clock);
    ctrl_start = 1'b1; op = 2'b11; shamt = 5'd10; data_in = 32'h8000_0011;
    @(posedge clock);
    #1 ctrl_start = 1'b0;
    repeat (3) @(posedge clock);
    #1 ctrl_abort = 1'b1;
    @(posedge clock);
    #1 ctrl_abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_partial", data_result, 32'h0000_008C);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (data_resultRDY || busy) seen++;
      @(posedge clock);
      #1;
    end
    check("abort_no_rdy", seen, 0);
    run_op(2'b00, 5'd2, 32'h0000_0003, -1, res, lat, bcyc);
    check("after_abort_sll2", res, 32'h0000_000C);
    check("after_abort_latency", lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
